// File: rtl/stream_qos_wrr_arbiter.sv
// stream_qos_wrr_arbiter: packet-level merge of STREAM_COUNT valid/ready streams by QoS with
// round-robin tie-break and a registered output stage. Define STREAM_ARB_AGING_EN for anti-starvation aging.
module stream_qos_wrr_arbiter #(
  parameter  int T_DATA_WIDTH = 8,
  parameter  int T_QOS_WIDTH  = 4,
  parameter  int STREAM_COUNT = 2,
  parameter  int AGE_LIMIT    = 8,
  localparam int T_ID_WIDTH   = (STREAM_COUNT > 1) ? $clog2(STREAM_COUNT) : 1
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [STREAM_COUNT-1:0][T_DATA_WIDTH-1:0] s_data_i,
  input  logic [STREAM_COUNT-1:0][T_QOS_WIDTH-1:0]  s_qos_i,
  input  logic [STREAM_COUNT-1:0]                   s_last_i,
  input  logic [STREAM_COUNT-1:0]                   s_valid_i,
  output logic [STREAM_COUNT-1:0]                   s_ready_o,
  output logic [T_DATA_WIDTH-1:0]                   m_data_o,
  output logic [T_QOS_WIDTH-1:0]                    m_qos_o,
  output logic [T_ID_WIDTH-1:0]                     m_id_o,
  output logic                                      m_last_o,
  output logic                                      m_valid_o,
  input  logic                                      m_ready_i
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Priority key: top bit marks a starved stream, which outranks every QoS value.
  localparam int KEY_W = T_QOS_WIDTH + 1;

  state_t                  state_q, state_d;
  logic [T_ID_WIDTH-1:0]   grant_q;
  logic [T_ID_WIDTH-1:0]   rr_ptr_q;
  logic [T_ID_WIDTH-1:0]   winner;
  logic [T_ID_WIDTH-1:0]   cand;
  logic [KEY_W-1:0]        key [STREAM_COUNT];
  logic [KEY_W-1:0]        best_key;
  logic                    found;
  logic                    any_valid;
  logic                    out_free;
  logic                    take;
  logic [STREAM_COUNT-1:0] aged;

  assign any_valid = |s_valid_i;
  assign out_free  = !m_valid_o || m_ready_i;

  function automatic logic [T_ID_WIDTH-1:0] scan_idx(input logic [T_ID_WIDTH-1:0] base,
                                                     input int offset);
    int s;
    s = (int'(base) + 1 + offset) % STREAM_COUNT;
    return T_ID_WIDTH'(s);
  endfunction

`ifdef STREAM_ARB_AGING_EN
  localparam int AGE_W = $clog2(AGE_LIMIT + 1);

  logic [AGE_W-1:0] age_q [STREAM_COUNT];

  // NOTE: the age counters steer arbitration, so every entry is reset rather than left unknown.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STREAM_COUNT; i++) age_q[i] <= '0;
    end else if (state_q == IDLE && any_valid) begin
      for (int i = 0; i < STREAM_COUNT; i++) begin
        if (winner == T_ID_WIDTH'(i)) begin
          age_q[i] <= '0;
        end else if (s_valid_i[i] && age_q[i] != AGE_W'(AGE_LIMIT)) begin
          age_q[i] <= age_q[i] + AGE_W'(1);
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < STREAM_COUNT; i++) aged[i] = (age_q[i] == AGE_W'(AGE_LIMIT));
  end
`else
  assign aged = '0;
`endif

  always_comb begin
    for (int i = 0; i < STREAM_COUNT; i++) begin
      key[i] = aged[i] ? {1'b1, {T_QOS_WIDTH{1'b0}}} : {1'b0, s_qos_i[i]};
    end
  end

  // Scan starting after the last packet's owner; strict '>' keeps the first of equal maxima.
  always_comb begin
    winner   = '0;
    cand     = '0;
    best_key = '0;
    found    = 1'b0;
    for (int i = 0; i < STREAM_COUNT; i++) begin
      cand = scan_idx(rr_ptr_q, i);
      if (s_valid_i[cand] && (!found || key[cand] > best_key)) begin
        found    = 1'b1;
        best_key = key[cand];
        winner   = cand;
      end
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    s_ready_o = '0;
    take      = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_valid) state_d = BUSY;
      end
      BUSY: begin
        for (int i = 0; i < STREAM_COUNT; i++) begin
          s_ready_o[i] = out_free && (grant_q == T_ID_WIDTH'(i));
        end
        take = out_free && s_valid_i[grant_q];
        if (take && s_last_i[grant_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignment so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q  <= '0;
      rr_ptr_q <= T_ID_WIDTH'(STREAM_COUNT - 1);
    end else begin
      if (state_q == IDLE && any_valid) grant_q <= winner;
      if (take && s_last_i[grant_q])    rr_ptr_q <= grant_q;
    end
  end

  // A new load and a drain can coincide; the load wins and keeps m_valid_o high.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_data_o  <= '0;
      m_qos_o   <= '0;
      m_id_o    <= '0;
      m_last_o  <= 1'b0;
      m_valid_o <= 1'b0;
    end else if (take) begin
      m_data_o  <= s_data_i[grant_q];
      m_qos_o   <= s_qos_i[grant_q];
      m_id_o    <= grant_q;
      m_last_o  <= s_last_i[grant_q];
      m_valid_o <= 1'b1;
    end else if (m_valid_o && m_ready_i) begin
      m_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_qos_wrr_arbiter.sv
// Self-checking bench for stream_qos_wrr_arbiter: per-cycle vector table plus packet-level
// scenarios (QoS, lock, backpressure, aging, mid-packet reset) checked against hand-built beat lists.
module tb_stream_qos_wrr_arbiter;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0][7:0] s_data;
  logic [1:0][3:0] s_qos;
  logic [1:0]      s_last;
  logic [1:0]      s_valid;
  logic [1:0]      s_ready;
  logic [7:0]      m_data;
  logic [3:0]      m_qos;
  logic            m_id;
  logic            m_last;
  logic            m_valid;
  logic            m_ready;

  int tests = 0;
  int fails = 0;

  stream_qos_wrr_arbiter #(
    .T_DATA_WIDTH(8),
    .T_QOS_WIDTH (4),
    .STREAM_COUNT(2),
    .AGE_LIMIT   (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .s_data_i (s_data),
    .s_qos_i  (s_qos),
    .s_last_i (s_last),
    .s_valid_i(s_valid),
    .s_ready_o(s_ready),
    .m_data_o (m_data),
    .m_qos_o  (m_qos),
    .m_id_o   (m_id),
    .m_last_o (m_last),
    .m_valid_o(m_valid),
    .m_ready_i(m_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] valid;
    logic [1:0] last;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [3:0] q0;
    logic [3:0] q1;
    logic       rdy;
    logic [1:0] e_sready;
    logic       e_valid;
    logic       e_id;
    logic [7:0] e_data;
    logic [3:0] e_qos;
    logic       e_last;
  } vec_t;

  vec_t vecs [20];

  // Packet-level scenario state
  logic [7:0] bdata  [2][16];
  logic       blast  [2][16];
  int         bcnt   [2];
  int         bstart [2];
  logic [3:0] bqos   [2];
  logic [9:0] exp_q  [$];
  logic [9:0] got_q  [$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [9:0] pk(input logic id, input logic [7:0] d, input logic l);
    return {id, d, l};
  endfunction

  task automatic clear_scenario();
    bcnt   = '{0, 0};
    bstart = '{0, 0};
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic add_pkt(input int s, input int n, input logic [7:0] base);
    for (int k = 0; k < n; k++) begin
      bdata[s][bcnt[s]] = base + 8'(k);
      blast[s][bcnt[s]] = (k == n - 1);
      bcnt[s]++;
    end
  endtask

  // Drives producers from the packet lists and records every beat the sink accepts.
  task automatic run_scenario(input string name, input int ready_mode);
    int         ptr [2];
    int         cyc;
    logic [1:0] acc;
    ptr = '{0, 0};
    cyc = 0;
    while (cyc < 300) begin
      if (ptr[0] == bcnt[0] && ptr[1] == bcnt[1] && !m_valid) break;
      for (int i = 0; i < 2; i++) begin
        s_valid[i] = (cyc >= bstart[i]) && (ptr[i] < bcnt[i]);
        s_data[i]  = (ptr[i] < bcnt[i]) ? bdata[i][ptr[i]] : 8'h00;
        s_last[i]  = (ptr[i] < bcnt[i]) ? blast[i][ptr[i]] : 1'b0;
        s_qos[i]   = bqos[i];
      end
      m_ready = (ready_mode == 0) || (cyc % 3 != 1);
      @(negedge clk);
      if (m_valid && m_ready) got_q.push_back(pk(m_id, m_data, m_last));
      if (m_valid && !m_ready) check($sformatf("%s stall cyc%0d s_ready", name, cyc), s_ready, 0);
      acc = s_valid & s_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) if (acc[i]) ptr[i]++;
      cyc++;
    end
    check({name, " completed in budget"}, cyc < 300, 1);
    s_valid = 2'b00;
    m_ready = 1'b1;
    check({name, " beat count"}, got_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      check($sformatf("%s beat%0d {id,data,last}", name, k), got_q[k], exp_q[k]);
    end
  endtask

  initial begin
    //          valid  last   d0     d1     q0    q1    rdy  | sready vld  id    data   qos   last
    vecs[0]  = '{2'b11, 2'b11, 8'h11, 8'h22, 4'd3, 4'd3, 1'b1, 2'b00, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0};
    vecs[1]  = '{2'b11, 2'b11, 8'h11, 8'h22, 4'd3, 4'd3, 1'b1, 2'b01, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0};
    vecs[2]  = '{2'b11, 2'b11, 8'h11, 8'h22, 4'd3, 4'd3, 1'b1, 2'b00, 1'b1, 1'b0, 8'h11, 4'd3, 1'b1};
    vecs[3]  = '{2'b11, 2'b11, 8'h11, 8'h22, 4'd3, 4'd3, 1'b1, 2'b10, 1'b0, 1'b0, 8'h11, 4'd3, 1'b1};
    vecs[4]  = '{2'b11, 2'b11, 8'h11, 8'h22, 4'd3, 4'd3, 1'b1, 2'b00, 1'b1, 1'b1, 8'h22, 4'd3, 1'b1};
    vecs[5]  = '{2'b11, 2'b11, 8'h11, 8'h22, 4'd3, 4'd3, 1'b1, 2'b01, 1'b0, 1'b1, 8'h22, 4'd3, 1'b1};
    vecs[6]  = '{2'b11, 2'b11, 8'h11, 8'h22, 4'd3, 4'd3, 1'b1, 2'b00, 1'b1, 1'b0, 8'h11, 4'd3, 1'b1};
    vecs[7]  = '{2'b11, 2'b11, 8'h11, 8'h22, 4'd3, 4'd3, 1'b1, 2'b10, 1'b0, 1'b0, 8'h11, 4'd3, 1'b1};
    vecs[8]  = '{2'b01, 2'b00, 8'hA1, 8'h22, 4'd6, 4'd3, 1'b0, 2'b00, 1'b1, 1'b1, 8'h22, 4'd3, 1'b1};
    vecs[9]  = '{2'b01, 2'b00, 8'hA1, 8'h22, 4'd6, 4'd3, 1'b0, 2'b00, 1'b1, 1'b1, 8'h22, 4'd3, 1'b1};
    vecs[10] = '{2'b01, 2'b00, 8'hA1, 8'h22, 4'd6, 4'd3, 1'b1, 2'b01, 1'b1, 1'b1, 8'h22, 4'd3, 1'b1};
    vecs[11] = '{2'b01, 2'b00, 8'hA2, 8'h22, 4'd6, 4'd3, 1'b0, 2'b00, 1'b1, 1'b0, 8'hA1, 4'd6, 1'b0};
    vecs[12] = '{2'b01, 2'b00, 8'hA2, 8'h22, 4'd6, 4'd3, 1'b0, 2'b00, 1'b1, 1'b0, 8'hA1, 4'd6, 1'b0};
    vecs[13] = '{2'b01, 2'b00, 8'hA2, 8'h22, 4'd6, 4'd3, 1'b0, 2'b00, 1'b1, 1'b0, 8'hA1, 4'd6, 1'b0};
    vecs[14] = '{2'b01, 2'b00, 8'hA2, 8'h22, 4'd6, 4'd3, 1'b0, 2'b00, 1'b1, 1'b0, 8'hA1, 4'd6, 1'b0};
    vecs[15] = '{2'b01, 2'b00, 8'hA2, 8'h22, 4'd6, 4'd3, 1'b1, 2'b01, 1'b1, 1'b0, 8'hA1, 4'd6, 1'b0};
    vecs[16] = '{2'b01, 2'b01, 8'hA3, 8'h22, 4'd6, 4'd3, 1'b1, 2'b01, 1'b1, 1'b0, 8'hA2, 4'd6, 1'b0};
    vecs[17] = '{2'b00, 2'b00, 8'hA3, 8'h22, 4'd6, 4'd3, 1'b0, 2'b00, 1'b1, 1'b0, 8'hA3, 4'd6, 1'b1};
    vecs[18] = '{2'b00, 2'b00, 8'hA3, 8'h22, 4'd6, 4'd3, 1'b1, 2'b00, 1'b1, 1'b0, 8'hA3, 4'd6, 1'b1};
    vecs[19] = '{2'b00, 2'b00, 8'hA3, 8'h22, 4'd6, 4'd3, 1'b1, 2'b00, 1'b0, 1'b0, 8'hA3, 4'd6, 1'b1};

    // Reset held two cycles with every producer valid
    rst     = 1'b1;
    s_valid = 2'b11;
    s_last  = 2'b11;
    s_data  = {8'h22, 8'h11};
    s_qos   = {4'd3, 4'd3};
    m_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset s_ready", s_ready, 0);
    check("reset m_valid", m_valid, 0);
    check("reset m_data", m_data, 0);
    check("reset m_qos", m_qos, 0);
    check("reset m_id", m_id, 0);
    check("reset m_last", m_last, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Round-robin alternation, then a backpressured 3-beat packet and output drain in IDLE
    for (int i = 0; i < 20; i++) begin
      s_valid = vecs[i].valid;
      s_last  = vecs[i].last;
      s_data  = {vecs[i].d1, vecs[i].d0};
      s_qos   = {vecs[i].q1, vecs[i].q0};
      m_ready = vecs[i].rdy;
      @(negedge clk);
      check($sformatf("vec%0d s_ready", i), s_ready, vecs[i].e_sready);
      check($sformatf("vec%0d m_valid", i), m_valid, vecs[i].e_valid);
      check($sformatf("vec%0d m_id", i), m_id, vecs[i].e_id);
      check($sformatf("vec%0d m_data", i), m_data, vecs[i].e_data);
      check($sformatf("vec%0d m_qos", i), m_qos, vecs[i].e_qos);
      check($sformatf("vec%0d m_last", i), m_last, vecs[i].e_last);
      @(posedge clk);
      #1;
    end

    // Higher QoS wins both-valid arbitration, with a free-running and then a stalling sink
    for (int r = 0; r < 2; r++) begin
      clear_scenario();
      bqos = '{4'd2, 4'd5};
      add_pkt(0, 3, 8'h01);
      add_pkt(1, 2, 8'h11);
      exp_q = '{pk(1, 8'h11, 0), pk(1, 8'h12, 1), pk(0, 8'h01, 0), pk(0, 8'h02, 0), pk(0, 8'h03, 1)};
      run_scenario(r == 0 ? "qos" : "qos_bp", r);
    end

    // A higher-QoS stream arriving mid-packet waits for the granted packet to end
    clear_scenario();
    bqos = '{4'd1, 4'd7};
    add_pkt(0, 4, 8'h31);
    add_pkt(1, 2, 8'h41);
    bstart = '{0, 2};
    exp_q = '{pk(0, 8'h31, 0), pk(0, 8'h32, 0), pk(0, 8'h33, 0), pk(0, 8'h34, 1),
              pk(1, 8'h41, 0), pk(1, 8'h42, 1)};
    run_scenario("lock", 0);

    // Low-QoS stream against a continuously busy high-QoS stream
    clear_scenario();
    bqos = '{4'd7, 4'd1};
    for (int k = 0; k < 8; k++) add_pkt(0, 1, 8'h01 + 8'(k));
    for (int k = 0; k < 2; k++) add_pkt(1, 1, 8'h81 + 8'(k));
`ifdef STREAM_ARB_AGING_EN
    exp_q = '{pk(0, 8'h01, 1), pk(0, 8'h02, 1), pk(1, 8'h81, 1), pk(0, 8'h03, 1), pk(0, 8'h04, 1),
              pk(1, 8'h82, 1), pk(0, 8'h05, 1), pk(0, 8'h06, 1), pk(0, 8'h07, 1), pk(0, 8'h08, 1)};
`else
    exp_q = '{pk(0, 8'h01, 1), pk(0, 8'h02, 1), pk(0, 8'h03, 1), pk(0, 8'h04, 1), pk(0, 8'h05, 1),
              pk(0, 8'h06, 1), pk(0, 8'h07, 1), pk(0, 8'h08, 1), pk(1, 8'h81, 1), pk(1, 8'h82, 1)};
`endif
    run_scenario("aging", 0);

    // Reset in the middle of a packet drops the output and returns to arbitration
    s_valid = 2'b01;
    s_last  = 2'b00;
    s_data  = {8'h00, 8'h55};
    s_qos   = {4'd0, 4'd0};
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    @(negedge clk);
    check("midrst pre m_valid", m_valid, 1);
    check("midrst pre m_data", m_data, 8'h55);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst m_valid", m_valid, 0);
    check("midrst m_data", m_data, 0);
    check("midrst s_ready", s_ready, 0);
    s_valid = 2'b11;
    s_last  = 2'b11;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("post-reset tie grant s_ready", s_ready, 2'b01);
    s_valid = 2'b00;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
